// File: rtl/pulse_hs_src.sv
// Source end of a 4-phase req/ack pulse crossing. Pulses are queued in a
// saturating counter and each one is launched as a full req/ack handshake.
module pulse_hs_src #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pulse_in,
  input  logic             ack_async,
  input  logic             clr_ovf,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   launch;

  // NOTE: every flop, synchroniser included, uses the async reset so that a
  // reset mid-handshake drops req_out at once and no stale ack survives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_s  = ack_sync[SYNC_STAGES-1];
  assign launch = (state == IDLE) && (pend_cnt != '0);

  // NOTE: pending counter saturates; a pulse arriving with the counter full
  // and no launch in the same cycle is dropped and flagged, never wrapped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      unique case ({pulse_in, launch})
        2'b10: begin
          if (pend_cnt != CNT_MAX) begin
            pend_cnt <= pend_cnt + CNT_ONE;
          end
        end
        2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
        default: pend_cnt <= pend_cnt;
      endcase

      // Setting on a dropped pulse takes priority over a concurrent clear.
      if (pulse_in && !launch && (pend_cnt == CNT_MAX)) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // NOTE: state and req_out are updated in one clocked block with
  // non-blocking assignments, so req_out is a clean registered level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      req_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // A stale ack_s here is deliberately ignored.
          if (launch) begin
            state   <= REQ;
            req_out <= 1'b1;
          end
        end
        REQ: begin
          if (ack_s) begin
            state   <= WAIT_LOW;
            req_out <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE) || (pend_cnt != '0);

endmodule

// File: tb/tb_pulse_hs_src.sv
// Scoreboard bench for pulse_hs_src: accepted pulses are queued when driven
// and retired when the DUT raises req_out; a behavioural responder drives ack.
module tb_pulse_hs_src;

  localparam int CNT_W = 2;
  localparam int SYNC  = 2;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             pulse_in = 1'b0;
  logic             ack_async = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             req_out;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             overflow;

  pulse_hs_src #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pulse_in  (pulse_in),
    .ack_async (ack_async),
    .clr_ovf   (clr_ovf),
    .req_out   (req_out),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   sb_q[$];
  int   next_id  = 0;
  logic exp_ovf  = 1'b0;
  logic prev_req = 1'b0;
  int   launches = 0;
  int   peak     = 0;
  bit   resp_en  = 1'b0;
  int   rcnt     = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One clock: update the scoreboard from the inputs seen at this edge,
  // compare, then let the responder react to what it sees.
  task automatic tick();
    logic p;
    logic c;
    logic dropped;
    p = pulse_in;
    c = clr_ovf;
    dropped = 1'b0;
    @(posedge clk);
    #1;
    if (req_out && !prev_req) begin
      launches++;
      check("launch_has_pending", int'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    prev_req = req_out;
    if (p) begin
      if (sb_q.size() < MAX) begin
        sb_q.push_back(next_id);
        next_id++;
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) exp_ovf = 1'b1;
    else if (c) exp_ovf = 1'b0;
    check("pend_cnt", int'(pend_cnt), sb_q.size());
    check("overflow", int'(overflow), int'(exp_ovf));
    if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
    if (resp_en) begin
      if (req_out != ack_async) begin
        rcnt++;
        if (rcnt == 3) begin
          ack_async = req_out;
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  endtask

  task automatic apply_reset(input logic ack_val);
    rstn      = 1'b0;
    ack_async = ack_val;
    pulse_in  = 1'b0;
    clr_ovf   = 1'b0;
    resp_en   = 1'b0;
    rcnt      = 0;
    sb_q.delete();
    exp_ovf   = 1'b0;
    prev_req  = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_req", int'(req_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(pend_cnt), 0);
    check("rst_ovf", int'(overflow), 0);
    apply_reset(1'b0);

    // Single pulse with responder
    resp_en  = 1'b1;
    launches = 0;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    check("single_cnt_n1", int'(pend_cnt), 1);
    check("single_req_n1", int'(req_out), 0);
    tick();
    check("single_req_n2", int'(req_out), 1);
    wait_idle(60, "single_idle");
    check("single_launches", launches, 1);
    check("single_req_end", int'(req_out), 0);
    check("single_cnt_end", int'(pend_cnt), 0);

    // Burst of three back-to-back pulses
    launches = 0;
    peak     = 0;
    pulse_in = 1'b1;
    repeat (3) tick();
    pulse_in = 1'b0;
    wait_idle(200, "burst_idle");
    check("burst_launches", launches, 3);
    check("burst_peak", peak, 2);
    check("burst_ovf", int'(overflow), 0);

    // Saturation with ack held low
    resp_en  = 1'b0;
    launches = 0;
    pulse_in = 1'b1;
    tick();
    check("sat_req_c1", int'(req_out), 0);
    tick();
    check("sat_req_c2", int'(req_out), 1);
    repeat (3) tick();
    pulse_in = 1'b0;
    check("sat_cnt", int'(pend_cnt), MAX);
    check("sat_ovf", int'(overflow), 1);
    check("sat_req", int'(req_out), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("sat_clr_ovf", int'(overflow), 0);
    check("sat_clr_cnt", int'(pend_cnt), MAX);

    // Drop and clear in the same cycle: set wins
    pulse_in = 1'b1;
    clr_ovf  = 1'b1;
    tick();
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    check("setclr_ovf", int'(overflow), 1);
    check("setclr_cnt", int'(pend_cnt), MAX);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // Pulse coinciding with a launch at max count
    ack_async = 1'b1;
    repeat (4) tick();
    check("sim_req_drop", int'(req_out), 0);
    ack_async = 1'b0;
    repeat (3) begin
      tick();
      check("sim_req_hold", int'(req_out), 0);
    end
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    check("sim_req_launch", int'(req_out), 1);
    check("sim_cnt", int'(pend_cnt), MAX);
    check("sim_ovf", int'(overflow), 0);

    // Reset in the middle of a handshake
    apply_reset(1'b0);
    pulse_in = 1'b1;
    repeat (3) tick();
    pulse_in = 1'b0;
    check("midrst_pre_cnt", int'(pend_cnt), 2);
    check("midrst_pre_req", int'(req_out), 1);
    #2 rstn = 1'b0;
    #1;
    check("midrst_req", int'(req_out), 0);
    check("midrst_cnt", int'(pend_cnt), 0);
    check("midrst_busy", int'(busy), 0);
    sb_q.delete();
    exp_ovf  = 1'b0;
    prev_req = 1'b0;
    @(posedge clk);
    #3 rstn = 1'b1;
    repeat (10) tick();
    check("midrst_post_req", int'(req_out), 0);

    // Stale ack held high through reset release
    apply_reset(1'b1);
    repeat (3) tick();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    check("stale_req_rise", int'(req_out), 1);
    tick();
    check("stale_wait_low", int'(req_out), 0);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (8) tick();
    check("stale_req_held", int'(req_out), 0);
    check("stale_cnt", int'(pend_cnt), 1);
    check("stale_busy", int'(busy), 1);
    ack_async = 1'b0;
    repeat (3) begin
      tick();
      check("stale_req_sync", int'(req_out), 0);
    end
    tick();
    check("stale_req_second", int'(req_out), 1);
    resp_en = 1'b1;
    wait_idle(60, "stale_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
